// File: rtl/game_flow_pkg.sv
// Shared types for the game flow controller: FSM state encodings, keyboard
// codes, end-cause codes and the Moore output decode used by the top.
package game_flow_pkg;

  typedef enum logic [3:0] {
    ST_START       = 4'd0,
    ST_PREPARE_MAP = 4'd1,
    ST_IDLE        = 4'd2,
    ST_JUMP_L      = 4'd3,
    ST_JUMP_R      = 4'd4,
    ST_FLY         = 4'd5,
    ST_FALL        = 4'd6,
    ST_RESPAWN     = 4'd7,
    ST_PAUSE       = 4'd8,
    ST_LEVEL_UP    = 4'd9,
    ST_END         = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    KEY_NONE  = 2'b00,
    KEY_LEFT  = 2'b01,
    KEY_RIGHT = 2'b10,
    KEY_SPACE = 2'b11
  } key_e;

  typedef enum logic [1:0] {
    END_NONE  = 2'b00,
    END_TIME  = 2'b01,
    END_LIVES = 2'b10,
    END_WIN   = 2'b11
  } end_code_e;

  typedef struct packed {
    logic start_screen;
    logic game_layer;
    logic end_screen;
    logic jump_left;
    logic jump_right;
    logic timer_start;
    logic timer_pause;
  } moore_t;

  // Unused encodings draw the start screen so they look exactly like START
  // for the single cycle before the FSM falls back to it.
  function automatic moore_t decode_state(state_e st);
    moore_t m;
    m = '0;
    case (st)
      ST_START, ST_PREPARE_MAP: m.start_screen = 1'b1;
      ST_IDLE, ST_FLY, ST_FALL, ST_LEVEL_UP: m.game_layer = 1'b1;
      ST_JUMP_L: begin
        m.game_layer = 1'b1;
        m.jump_left  = 1'b1;
      end
      ST_JUMP_R: begin
        m.game_layer = 1'b1;
        m.jump_right = 1'b1;
      end
      ST_RESPAWN: begin
        m.game_layer  = 1'b1;
        m.timer_start = 1'b1;
      end
      ST_PAUSE: begin
        m.game_layer  = 1'b1;
        m.timer_pause = 1'b1;
      end
      ST_END:  m.end_screen = 1'b1;
      default: m.start_screen = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/game_flow_fsm_if.sv
// Signal bundle between the game flow controller and its neighbours
// (keyboard decoder, map generator, timer, character and drawing blocks).
interface game_flow_fsm_if #(
  parameter int LIFE_W = 2,
  parameter int LVL_W  = 2
);
  logic [1:0]        key;
  logic              map_ready;
  logic              jump_fail;
  logic              time_elapsed;
  logic              character_landed;
  logic              level_done;

  logic              start_screen_en;
  logic              blocks_en;
  logic              time_bar_en;
  logic              character_en;
  logic              points_en;
  logic              end_screen_en;
  logic              bg_color_select;
  logic              jump_left;
  logic              jump_right;
  logic              timer_start;
  logic              timer_pause;
  logic [1:0]        end_code;
  logic [LVL_W-1:0]  level;
  logic [LIFE_W-1:0] lives;

  modport master (
    output key, map_ready, jump_fail, time_elapsed, character_landed, level_done,
    input  start_screen_en, blocks_en, time_bar_en, character_en, points_en,
           end_screen_en, bg_color_select, jump_left, jump_right, timer_start,
           timer_pause, end_code, level, lives
  );

  modport slave (
    input  key, map_ready, jump_fail, time_elapsed, character_landed, level_done,
    output start_screen_en, blocks_en, time_bar_en, character_en, points_en,
           end_screen_en, bg_color_select, jump_left, jump_right, timer_start,
           timer_pause, end_code, level, lives
  );
endinterface

// File: rtl/game_flow_fsm_key_event_detect.sv
// Turns the level-coded keyboard bus into single-cycle key events: a key
// counts once when it appears or changes, never while it is held.
module key_event_detect
  import game_flow_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] key_i,
  output logic       key_ev_o,
  output key_e       key_code_o
);

  logic [1:0] key_prev_q;

  // Resetting to spacebar means a space held through reset is not an event.
  // NOTE: clocked state is assigned with <= so every flop samples the
  // pre-edge values, independent of process ordering in simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_prev_q <= KEY_SPACE;
    else     key_prev_q <= key_i;
  end

  assign key_ev_o   = (key_i != KEY_NONE) && (key_i != key_prev_q);
  assign key_code_o = key_e'(key_i);

endmodule

// File: rtl/game_flow_fsm.sv
// Game flow controller: start screen, map preparation, play with jumps and
// falls, pause, level progression, a finite life count and end screens.
module game_flow_fsm
  import game_flow_pkg::*;
#(
  parameter int LIVES  = 3,
  parameter int LEVELS = 4,
  parameter int LIFE_W = 2,
  parameter int LVL_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  game_flow_fsm_if.slave   bus
);

  state_e            state_q, state_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [LIFE_W-1:0] lives_q, lives_d;
  end_code_e         end_code_q, end_code_d;

  logic   key_ev;
  key_e   key_code;
  logic   space_ev, left_ev, right_ev;
  logic   map_start;
  moore_t moore;

  key_event_detect u_key_event_detect (
    .clk       (clk),
    .rst       (rst),
    .key_i     (bus.key),
    .key_ev_o  (key_ev),
    .key_code_o(key_code)
  );

  assign space_ev = key_ev && (key_code == KEY_SPACE);
  assign left_ev  = key_ev && (key_code == KEY_LEFT);
  assign right_ev = key_ev && (key_code == KEY_RIGHT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_START;
      level_q    <= '0;
      lives_q    <= LIFE_W'(LIVES);
      end_code_q <= END_NONE;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      lives_q    <= lives_d;
      end_code_q <= end_code_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    lives_d    = lives_q;
    end_code_d = end_code_q;
    map_start  = 1'b0;

    case (state_q)
      ST_START: begin
        if (space_ev) begin
          state_d    = ST_PREPARE_MAP;
          level_d    = '0;
          lives_d    = LIFE_W'(LIVES);
          end_code_d = END_NONE;
        end
      end

      ST_PREPARE_MAP: begin
        if (bus.map_ready) begin
          state_d   = ST_IDLE;
          map_start = 1'b1;
        end
      end

      ST_IDLE: begin
        if (bus.jump_fail) begin
          state_d = ST_FALL;
        end else if (bus.time_elapsed) begin
          state_d    = ST_END;
          end_code_d = END_TIME;
        end else if (bus.level_done) begin
          state_d = ST_LEVEL_UP;
        end else if (space_ev) begin
          state_d = ST_PAUSE;
        end else if (left_ev) begin
          state_d = ST_JUMP_L;
        end else if (right_ev) begin
          state_d = ST_JUMP_R;
        end
      end

      ST_JUMP_L, ST_JUMP_R: state_d = ST_FLY;

      // A timeout seen mid-flight is picked up once the character is back in IDLE.
      ST_FLY: begin
        if (bus.character_landed) state_d = ST_IDLE;
      end

      ST_FALL: begin
        if (bus.character_landed) begin
          if (lives_q > LIFE_W'(1)) begin
            lives_d = lives_q - LIFE_W'(1);
            state_d = ST_RESPAWN;
          end else begin
            lives_d    = '0;
            end_code_d = END_LIVES;
            state_d    = ST_END;
          end
        end
      end

      ST_RESPAWN: state_d = ST_IDLE;

      ST_PAUSE: begin
        if (space_ev) state_d = ST_IDLE;
      end

      ST_LEVEL_UP: begin
        if (level_q == LVL_W'(LEVELS - 1)) begin
          end_code_d = END_WIN;
          state_d    = ST_END;
        end else begin
          level_d = level_q + LVL_W'(1);
          state_d = ST_PREPARE_MAP;
        end
      end

      ST_END: begin
        if (space_ev) state_d = ST_START;
      end

      default: state_d = ST_START;
    endcase
  end

  // Pulses decode from the state register, so reset clears them immediately.
  assign moore = decode_state(state_q);

  assign bus.start_screen_en = moore.start_screen;
  assign bus.blocks_en       = moore.game_layer;
  assign bus.time_bar_en     = moore.game_layer;
  assign bus.character_en    = moore.game_layer;
  assign bus.points_en       = moore.game_layer;
  assign bus.bg_color_select = moore.game_layer;
  assign bus.end_screen_en   = moore.end_screen;
  assign bus.jump_left       = moore.jump_left;
  assign bus.jump_right      = moore.jump_right;
  assign bus.timer_pause     = moore.timer_pause;
  assign bus.timer_start     = moore.timer_start | map_start;
  assign bus.end_code        = end_code_q;
  assign bus.level           = level_q;
  assign bus.lives           = lives_q;

endmodule
